// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter time-sharing the seven-segment display between NREQ requesters,
// with a guaranteed minimum dwell and optional pre-emption of long holders.
module seg_display_arbiter #(
  parameter int             N            = 32,
  parameter int             NREQ         = 4,
  parameter int             DWELL_CYCLES = 4,
  parameter int             MAX_HOLD     = 8,
  parameter logic [N-1:0]   IDLE_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*N-1:0]       data,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [N-1:0]            din_o
);
  localparam int IW = $clog2(NREQ);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(MAX_HOLD + 2);

  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

  state_t                 st;
  logic [IW-1:0]          ptr;
  logic [DW-1:0]          dwell_cnt;
  logic [TW-1:0]          tenure;
  logic [NREQ-1:0][N-1:0] lane;
  logic [NREQ-1:0]        others;
  logic [IW:0]            pick_all, pick_oth;
  logic                   do_grant, go_idle, counting;
  logic [IW-1:0]          gidx;

  assign lane   = data;
  assign others = req & ~(NREQ'(1) << owner);

  // Returns {found, index}: first set bit of r scanning from start upward, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    logic [IW:0] res;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int unsigned i;
      i = (int'(start) + k) % NREQ;
      if (r[i]) res = {1'b1, IW'(i)};
    end
    return res;
  endfunction

  assign pick_all = rr_pick(req, ptr);
  assign pick_oth = rr_pick(others, ptr);

  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    counting = 1'b0;
    gidx     = pick_all[IW-1:0];
    if (st == IDLE) begin
      do_grant = pick_all[IW];
    end else if (st == DWELL && dwell_cnt != '0) begin
      counting = 1'b1;
    end else if (!req[owner]) begin
      // ptr sits just past the owner, so masking the owner yields the next in line
      if (pick_oth[IW]) begin
        do_grant = 1'b1;
        gidx     = pick_oth[IW-1:0];
      end else begin
        go_idle = 1'b1;
      end
    end else if (MAX_HOLD != 0 && pick_oth[IW] && tenure == TW'(MAX_HOLD)) begin
      do_grant = 1'b1;
      gidx     = pick_oth[IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= IDLE;
      ptr       <= '0;
      dwell_cnt <= '0;
      tenure    <= '0;
      grant     <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      din_o     <= IDLE_VALUE;
    end else if (do_grant) begin
      st        <= DWELL;
      ptr       <= IW'((int'(gidx) + 1) % NREQ);
      dwell_cnt <= DW'(DWELL_CYCLES - 1);
      tenure    <= TW'(1);
      grant     <= NREQ'(1) << gidx;
      owner     <= gidx;
      busy      <= 1'b1;
      din_o     <= lane[gidx];
    end else if (st == IDLE || go_idle) begin
      st    <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      din_o <= IDLE_VALUE;
    end else begin
      if (counting) dwell_cnt <= dwell_cnt - 1'b1;
      else          st        <= HOLD;
      if (MAX_HOLD != 0 && tenure < TW'(MAX_HOLD)) tenure <= tenure + 1'b1;
      din_o <= lane[owner];
    end
  end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the multiplexed seven-segment display between up to NREQ requesters, such as a debug counter, a status word or an error code. Each requester holds a level request and presents its N-bit value. The arbiter grants the display round-robin, guarantees each owner a minimum on-screen dwell time, and optionally pre-empts long holders. Its registered data output feeds the `din` input of the `display` block directly.

## Interface
- N, 32: display data width in bits; N/4 hex digits.
- NREQ, 4: number of requesters, ≥2.
- DWELL_CYCLES, 4: minimum grant tenure in clk cycles, ≥1.
- MAX_HOLD, 8: tenure after which a holder is pre-empted if another request is pending. 0 disables pre-emption. If nonzero, it must be ≥ DWELL_CYCLES.
- IDLE_VALUE, 0: value driven on din_o while no requester owns the display.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester level request.
- data  in  NREQ*N  requester i value at bits [i*N+N-1 : i*N].
- grant  out  NREQ  one-hot registered grant; all zero when idle.
- owner  out  $clog2(NREQ)  index of current or last owner.
- busy  out  1  high while any grant is active.
- din_o  out  N  registered display value; connects to `display.din`.

## Operation
- States:
  - IDLE: no owner.
  - DWELL: owner locked for the minimum time.
  - HOLD: owner may release or be pre-empted.
- Round-robin pointer `ptr`:
  - Search starts at `ptr`, then `ptr+1`, and so on modulo NREQ.
  - The first index with `req` high wins.
  - On every new grant, `ptr` becomes (winner+1) mod NREQ.
- IDLE:
  - If any `req` is high, the winner is granted: state goes to DWELL, `dwell_cnt` loads DWELL_CYCLES-1, and `tenure` loads 1.
  - Otherwise the block stays in IDLE with `din_o` = IDLE_VALUE.
- DWELL:
  - The owner cannot be displaced. Its `req` is ignored.
  - `dwell_cnt` decrements each cycle.
  - When `dwell_cnt`==0, the HOLD decision rules below apply in that same cycle. Otherwise the state moves to HOLD.
- HOLD, and DWELL with `dwell_cnt`==0 (the release-eligible cycles):
  - Owner `req` low and another `req` high: switch to the next round-robin winner, which excludes the old owner, and enter DWELL.
  - Owner `req` low and no other `req`: go to IDLE. `grant` clears and `din_o` reverts to IDLE_VALUE.
  - Owner `req` high, another `req` high, MAX_HOLD≠0 and `tenure`==MAX_HOLD: pre-empt and switch as above.
  - Otherwise stay; `tenure` increments and saturates at MAX_HOLD.
- While granted, `din_o` is registered from the owner's `data` slice every cycle, so changes in the owner's data appear live.
- Reset (`rst`==0 at a clk edge): all state clears regardless of the current state, including mid-dwell.

## Timing
- Reset values:
  - `grant`=0, `owner`=0, `busy`=0, `din_o`=IDLE_VALUE.
  - `ptr`=0, state IDLE, counters 0.
- Grant latency: `req` sampled at edge t gives `grant`, `busy`, `owner` and `din_o` (holding data sampled at t) all valid after edge t.
- Owner data change at edge t appears on `din_o` after edge t (1-cycle latency).
- Switchover is gapless: `grant` moves from A to B on a single edge, `busy` stays high, and `din_o` changes on that same edge.
- Minimum grant width is DWELL_CYCLES cycles. With pre-emption, maximum grant width is MAX_HOLD cycles when contended and unbounded when uncontended.
- Release when idle-bound: `grant` drops on the edge where the owner's `req` is first seen low in a release-eligible cycle.
- Simultaneous requests: only the round-robin winner is granted; the others wait with no extra penalty cycles.
- Outputs are fully registered; there are no combinational paths from `req` or `data` to outputs.

## Test plan
All scenarios use N=32, NREQ=4, DWELL_CYCLES=4, MAX_HOLD=8, IDLE_VALUE=0.
- Reset values: hold `rst`=0 for 3 cycles with `req`=4'b1111 → `grant`=0, `busy`=0, `din_o`=32'h0, `owner`=0; after `rst` rises, `grant`=4'b0001 one cycle later.
- Single request: `req[2]`=1 with `data[2]`=32'hDEADBEEF, dropped after 1 cycle → `grant`=4'b0100 for exactly 4 cycles with `din_o`=32'hDEADBEEF, then `grant`=0 and `din_o`=32'h0.
- Round-robin order: `req`=4'b1011 held constant → owners follow 0,1,3,0,… with each tenure 8 cycles (pre-emption) and no idle gap between owners.
- Dwell enforcement: `req[1]` pulses for 1 cycle while `req[3]` is held high → `grant[1]` is high exactly 4 cycles, then `grant`=4'b1000 on the next edge.
- No pre-emption when uncontended: `req[0]` held high for 20 cycles alone → `grant[0]` high for all 20 cycles; `data[0]` stepping 1,2,3 appears on `din_o` one cycle after each change.
- Reset mid-dwell: `rst`=0 during cycle 2 of the `grant[2]` tenure → `grant`=0 and `ptr`=0 on the next edge; after release with `req`=4'b0101, requester 0 is granted first.
